// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style interrupt acknowledge sequencer.
package pic_pkg;

    localparam int NUM_IR = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        WAIT2,
        ACK2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] level;
    } hit_t;

    function automatic logic [2:0] onehot_to_level(input logic [NUM_IR-1:0] v);
        logic [2:0] lvl;
        lvl = '0;
        for (int i = 0; i < NUM_IR; i++) begin
            if (v[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

    // First set bit encountered when walking upward from rot, wrapping 7 -> 0.
    function automatic hit_t rotated_highest(input logic [NUM_IR-1:0] isr,
                                             input logic [2:0]        rot);
        hit_t       h;
        logic [2:0] idx;
        h = '0;
        for (int k = 0; k < NUM_IR; k++) begin
            idx = rot + 3'(k);
            if (!h.found && isr[idx]) begin
                h.found = 1'b1;
                h.level = idx;
            end
        end
        return h;
    endfunction

endpackage

// File: rtl/pic_interrupt_sequencer_eoi_unit.sv
// Combinational EOI decode: ISR clear mask and next priority rotation.
module pic_eoi_unit
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] isr,
    input  logic [2:0]        priority_rotate,
    input  logic              eoi_valid,
    input  logic              eoi_specific,
    input  logic              eoi_rotate,
    input  logic              set_priority,
    input  logic [2:0]        eoi_level,
    output logic [NUM_IR-1:0] isr_clear,
    output logic [2:0]        rotate_next
);

    hit_t       hit;
    logic [2:0] clear_level;
    logic       cleared;

    always_comb begin
        hit         = rotated_highest(isr, priority_rotate);
        clear_level = eoi_specific ? eoi_level : hit.level;
        // A non-specific EOI with an empty ISR clears nothing and must not rotate.
        cleared     = eoi_valid && (eoi_specific || hit.found);
        isr_clear   = '0;
        rotate_next = priority_rotate;
        if (cleared) isr_clear[clear_level] = 1'b1;
        if (set_priority) rotate_next = eoi_level + 3'd1;
        if (cleared && eoi_rotate) rotate_next = clear_level + 3'd1;
    end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259 interrupt acknowledge sequencer: INT/INTA handshake, ISR bookkeeping,
// vector drive, and EOI / rotation processing around the external resolver.
module pic_interrupt_sequencer
    import pic_pkg::*;
#(
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7,
    parameter logic [2:0] ROTATE_RESET   = 3'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] interrupt_vector,
    input  logic              inta_n,
    input  logic [4:0]        icw2_base,
    input  logic              aeoi,
    input  logic              eoi_valid,
    input  logic              eoi_specific,
    input  logic              eoi_rotate,
    input  logic              set_priority,
    input  logic [2:0]        eoi_level,
    output logic [NUM_IR-1:0] isr,
    output logic [2:0]        priority_rotate,
    output logic              int_out,
    output logic [NUM_IR-1:0] clear_irr,
    output logic [7:0]        data_out,
    output logic              data_out_en
);

    state_e            state_q, state_d;
    logic              inta_q;
    logic [2:0]        level_q, level_d;
    logic              spurious_q, spurious_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic [2:0]        rot_q, rot_d;
    logic              int_q, int_d;
    logic [NUM_IR-1:0] clear_irr_q, clear_irr_d;
    logic [7:0]        data_q, data_d;
    logic              data_en_q, data_en_d;

    logic              inta_fall, inta_rise;
    logic [2:0]        req_level;
    logic [NUM_IR-1:0] eoi_clear;
    logic [2:0]        eoi_rot_next;

    assign inta_fall = inta_q & ~inta_n;
    assign inta_rise = ~inta_q & inta_n;
    assign req_level = onehot_to_level(interrupt_vector);

    pic_eoi_unit u_eoi (
        .isr             (isr_q),
        .priority_rotate (rot_q),
        .eoi_valid       (eoi_valid),
        .eoi_specific    (eoi_specific),
        .eoi_rotate      (eoi_rotate),
        .set_priority    (set_priority),
        .eoi_level       (eoi_level),
        .isr_clear       (eoi_clear),
        .rotate_next     (eoi_rot_next)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path infers a latch.
        state_d     = state_q;
        level_d     = level_q;
        spurious_d  = spurious_q;
        isr_d       = isr_q & ~eoi_clear;
        rot_d       = eoi_rot_next;
        int_d       = 1'b0;
        clear_irr_d = '0;
        data_d      = data_q;
        data_en_d   = data_en_q;

        unique case (state_q)
            IDLE: begin
                int_d = |interrupt_vector;
                if (inta_fall) begin
                    state_d = ACK1;
                    int_d   = 1'b0;
                    if (|interrupt_vector) begin
                        level_d                = req_level;
                        spurious_d             = 1'b0;
                        isr_d[req_level]       = 1'b1;
                        clear_irr_d[req_level] = 1'b1;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_d = WAIT2;
            end
            WAIT2: begin
                if (inta_fall) begin
                    state_d   = ACK2;
                    data_d    = {icw2_base, level_q};
                    data_en_d = 1'b1;
                end
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d   = IDLE;
                    data_en_d = 1'b0;
                    if (aeoi && !spurious_q) isr_d[level_q] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            inta_q      <= 1'b1;
            level_q     <= '0;
            spurious_q  <= 1'b0;
            isr_q       <= '0;
            rot_q       <= ROTATE_RESET;
            int_q       <= 1'b0;
            clear_irr_q <= '0;
            data_q      <= '0;
            data_en_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values of the others.
            state_q     <= state_d;
            inta_q      <= inta_n;
            level_q     <= level_d;
            spurious_q  <= spurious_d;
            isr_q       <= isr_d;
            rot_q       <= rot_d;
            int_q       <= int_d;
            clear_irr_q <= clear_irr_d;
            data_q      <= data_d;
            data_en_q   <= data_en_d;
        end
    end

    assign isr             = isr_q;
    assign priority_rotate = rot_q;
    assign int_out         = int_q;
    assign clear_irr       = clear_irr_q;
    assign data_out        = data_q;
    assign data_out_en     = data_en_q;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Self-checking bench: table of handshake / EOI steps plus a reset-in-WAIT2 sequence.
module tb_pic_interrupt_sequencer;

    typedef enum {OP_HS, OP_EOI} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] vec;
        logic [4:0] base;
        logic       aeoi;
        logic       collide;
        logic       ev;
        logic       spec;
        logic       rot;
        logic       setp;
        logic [2:0] lvl;
        logic       exp_int;
        logic [7:0] exp_clear;
        logic [7:0] exp_isr_ack;
        logic [7:0] exp_data;
        logic [7:0] exp_isr;
        logic [2:0] exp_rot;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] interrupt_vector;
    logic       inta_n;
    logic [4:0] icw2_base;
    logic       aeoi;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic       set_priority;
    logic [2:0] eoi_level;
    logic [7:0] isr;
    logic [2:0] priority_rotate;
    logic       int_out;
    logic [7:0] clear_irr;
    logic [7:0] data_out;
    logic       data_out_en;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    vec_t       tbl[$];

    pic_interrupt_sequencer #(
        .SPURIOUS_LEVEL (3'd7),
        .ROTATE_RESET   (3'd0)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .interrupt_vector (interrupt_vector),
        .inta_n           (inta_n),
        .icw2_base        (icw2_base),
        .aeoi             (aeoi),
        .eoi_valid        (eoi_valid),
        .eoi_specific     (eoi_specific),
        .eoi_rotate       (eoi_rotate),
        .set_priority     (set_priority),
        .eoi_level        (eoi_level),
        .isr              (isr),
        .priority_rotate  (priority_rotate),
        .int_out          (int_out),
        .clear_irr        (clear_irr),
        .data_out         (data_out),
        .data_out_en      (data_out_en)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t hs(input logic [7:0] vec, input logic [4:0] base,
                                input logic a, input logic col,
                                input logic [7:0] clr, input logic [7:0] isr_ack,
                                input logic [7:0] dat, input logic [7:0] isr_end,
                                input logic [2:0] rot);
        vec_t r;
        r = '{op: OP_HS, vec: vec, base: base, aeoi: a, collide: col, ev: 1'b0,
              spec: 1'b0, rot: 1'b0, setp: 1'b0, lvl: 3'd0, exp_int: (vec != 8'h00),
              exp_clear: clr, exp_isr_ack: isr_ack, exp_data: dat, exp_isr: isr_end,
              exp_rot: rot};
        return r;
    endfunction

    function automatic vec_t eo(input logic ev, input logic spec, input logic rot,
                                input logic setp, input logic [2:0] lvl,
                                input logic [7:0] isr_exp, input logic [2:0] rot_exp);
        vec_t r;
        r = '{op: OP_EOI, vec: 8'h00, base: 5'h00, aeoi: 1'b0, collide: 1'b0, ev: ev,
              spec: spec, rot: rot, setp: setp, lvl: lvl, exp_int: 1'b0,
              exp_clear: 8'h00, exp_isr_ack: 8'h00, exp_data: 8'h00, exp_isr: isr_exp,
              exp_rot: rot_exp};
        return r;
    endfunction

    function automatic logic [2:0] level_of(input logic [7:0] v);
        logic [2:0] l;
        l = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) l = 3'(i);
        return l;
    endfunction

    task automatic run_hs(input vec_t r);
        int lat;
        interrupt_vector = r.vec;
        icw2_base        = r.base;
        aeoi             = r.aeoi;
        inta_n           = 1'b1;
        tick();
        tick();
        check("int_out before INTA", {7'd0, int_out}, {7'd0, r.exp_int});
        inta_n = 1'b0;
        if (r.collide) begin
            eoi_valid    = 1'b1;
            eoi_specific = 1'b1;
            eoi_level    = level_of(r.vec);
        end
        tick();
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        check("clear_irr after first fall", clear_irr, r.exp_clear);
        check("isr after first fall", isr, r.exp_isr_ack);
        check("int_out in ACK1", {7'd0, int_out}, 8'd0);
        interrupt_vector = 8'h00;
        tick();
        check("clear_irr one cycle", clear_irr, 8'h00);
        inta_n = 1'b1;
        tick();
        tick();
        check("data_out_en before second fall", {7'd0, data_out_en}, 8'd0);
        inta_n = 1'b0;
        sb.push_back(r.exp_data);
        lat = 0;
        for (int i = 1; i <= 4 && lat == 0; i++) begin
            tick();
            if (data_out_en) lat = i;
        end
        check("data_out_en latency", 8'(lat), 8'd1);
        check("data_out vector", data_out, sb.pop_front());
        tick();
        check("isr during second low", isr, r.exp_isr_ack);
        inta_n = 1'b1;
        tick();
        check("data_out_en after second rise", {7'd0, data_out_en}, 8'd0);
        check("isr after second rise", isr, r.exp_isr);
        check("priority_rotate after handshake", {5'd0, priority_rotate}, {5'd0, r.exp_rot});
        tick();
    endtask

    task automatic run_eoi(input vec_t r);
        eoi_valid    = r.ev;
        eoi_specific = r.spec;
        eoi_rotate   = r.rot;
        set_priority = r.setp;
        eoi_level    = r.lvl;
        tick();
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
        set_priority = 1'b0;
        check("isr after EOI", isr, r.exp_isr);
        check("priority_rotate after EOI", {5'd0, priority_rotate}, {5'd0, r.exp_rot});
    endtask

    initial begin
        tbl.push_back(hs(8'h08, 5'h10, 1'b0, 1'b0, 8'h08, 8'h08, 8'h83, 8'h08, 3'd0));
        tbl.push_back(hs(8'h01, 5'h1F, 1'b0, 1'b0, 8'h01, 8'h09, 8'hF8, 8'h09, 3'd0));
        tbl.push_back(hs(8'h80, 5'h05, 1'b1, 1'b0, 8'h80, 8'h89, 8'h2F, 8'h09, 3'd0));
        tbl.push_back(hs(8'h00, 5'h10, 1'b1, 1'b0, 8'h00, 8'h09, 8'h87, 8'h09, 3'd0));
        tbl.push_back(hs(8'h20, 5'h00, 1'b1, 1'b0, 8'h20, 8'h29, 8'h05, 8'h09, 3'd0));
        tbl.push_back(eo(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h08, 3'd0));
        tbl.push_back(eo(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 3'd4));
        tbl.push_back(eo(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 3'd4));
        tbl.push_back(eo(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 8'h00, 3'd0));
        tbl.push_back(hs(8'h04, 5'h10, 1'b0, 1'b0, 8'h04, 8'h04, 8'h82, 8'h04, 3'd0));
        tbl.push_back(hs(8'h20, 5'h10, 1'b0, 1'b0, 8'h20, 8'h24, 8'h85, 8'h24, 3'd0));
        tbl.push_back(eo(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h20, 3'd3));
        tbl.push_back(eo(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 3'd6));
        tbl.push_back(hs(8'h02, 5'h01, 1'b0, 1'b0, 8'h02, 8'h02, 8'h09, 8'h02, 3'd6));
        tbl.push_back(hs(8'h10, 5'h01, 1'b0, 1'b0, 8'h10, 8'h12, 8'h0C, 8'h12, 3'd6));
        tbl.push_back(eo(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10, 3'd6));
        tbl.push_back(eo(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 3'd6));
        tbl.push_back(hs(8'h04, 5'h10, 1'b0, 1'b0, 8'h04, 8'h04, 8'h82, 8'h04, 3'd6));
        tbl.push_back(hs(8'h04, 5'h10, 1'b0, 1'b1, 8'h04, 8'h04, 8'h82, 8'h04, 3'd6));
        tbl.push_back(eo(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 3'd6));

        reset            = 1'b1;
        interrupt_vector = 8'h00;
        inta_n           = 1'b1;
        icw2_base        = 5'h00;
        aeoi             = 1'b0;
        eoi_valid        = 1'b0;
        eoi_specific     = 1'b0;
        eoi_rotate       = 1'b0;
        set_priority     = 1'b0;
        eoi_level        = 3'd0;
        tick();
        tick();
        reset = 1'b0;
        check("reset isr", isr, 8'h00);
        check("reset priority_rotate", {5'd0, priority_rotate}, 8'd0);
        check("reset int_out", {7'd0, int_out}, 8'd0);
        check("reset clear_irr", clear_irr, 8'h00);
        check("reset data_out", data_out, 8'h00);
        check("reset data_out_en", {7'd0, data_out_en}, 8'd0);

        foreach (tbl[i]) begin
            if (tbl[i].op == OP_HS) run_hs(tbl[i]);
            else                    run_eoi(tbl[i]);
        end

        // Reset while parked in WAIT2, then one more INTA pulse with nothing pending.
        interrupt_vector = 8'h08;
        icw2_base        = 5'h10;
        tick();
        tick();
        inta_n = 1'b0;
        tick();
        interrupt_vector = 8'h00;
        inta_n = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset in WAIT2 isr", isr, 8'h00);
        check("reset in WAIT2 priority_rotate", {5'd0, priority_rotate}, 8'd0);
        check("reset in WAIT2 int_out", {7'd0, int_out}, 8'd0);
        check("reset in WAIT2 data_out_en", {7'd0, data_out_en}, 8'd0);
        check("reset in WAIT2 data_out", data_out, 8'h00);
        inta_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("data_out_en after reset, INTA low", {7'd0, data_out_en}, 8'd0);
        end
        inta_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("data_out_en after reset, INTA high", {7'd0, data_out_en}, 8'd0);
        end
        check("isr after post-reset INTA", isr, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
Sequences the 8259 interrupt acknowledge cycle around the combinational priority resolver. Raises INT toward the CPU, runs the two-pulse INTA handshake (8086 mode), and sets the selected ISR bit and clears the IRR bit. Drives the vector byte onto the data bus, processes EOI and rotation commands, and owns the `priority_rotate` value fed back to the resolver.

Parameters:
SPURIOUS_LEVEL, 3'd7, level reported in the vector when no request is resolved at the first INTA.
ROTATE_RESET, 3'd0, reset value of `priority_rotate` (IR0 highest).

Ports:
clk  in  1  single system clock
reset  in  1  synchronous, active-high reset
interrupt_vector  in  8  one-hot resolved request from the priority resolver; 0 = none
inta_n  in  1  CPU acknowledge strobe, active-low, already synchronous to `clk`
icw2_base  in  5  vector base T7..T3
aeoi  in  1  automatic-EOI mode enable
eoi_valid  in  1  one-cycle OCW2 strobe
eoi_specific  in  1  1 = specific EOI at `eoi_level`; 0 = non-specific
eoi_rotate  in  1  rotate on this EOI
set_priority  in  1  one-cycle strobe: make `eoi_level`+1 highest priority, no ISR change
eoi_level  in  3  level operand for specific EOI or `set_priority`
isr  out  8  in-service register
priority_rotate  out  3  highest-priority level, fed to the resolver
int_out  out  1  interrupt request to CPU
clear_irr  out  8  one-cycle one-hot pulse clearing the serviced IRR bit
data_out  out  8  vector byte
data_out_en  out  1  data bus drive enable

Behaviour:
- Reset values: `isr`=0, `priority_rotate`=`ROTATE_RESET`, `int_out`=0, `clear_irr`=0, `data_out`=0, `data_out_en`=0. State=IDLE and the internal `inta_n` delay register=1.
- Edge detect: `inta_fall` = `inta_q` & ~`inta_n`; `inta_rise` = ~`inta_q` & `inta_n`.
- States:
  - IDLE: `int_out` is registered and equals (`interrupt_vector`!=0), one-cycle latency. On `inta_fall`, go to ACK1:
    - latch `level` = encode(`interrupt_vector`);
    - set `isr[level]`;
    - pulse `clear_irr[level]` for exactly one cycle;
    - deassert `int_out`.
    - If `interrupt_vector`==0, this is a spurious acknowledge: `level`=`SPURIOUS_LEVEL`, no ISR set, no `clear_irr`.
  - ACK1: wait for `inta_rise`, then go to WAIT2.
  - WAIT2: on `inta_fall`, go to ACK2. Set `data_out`={`icw2_base`,`level`} and `data_out_en`=1 from the next cycle.
  - ACK2: on `inta_rise`, set `data_out_en`=0 and return to IDLE. If `aeoi` is set and the cycle was not spurious, clear `isr[level]` in that same cycle.
- `int_out` stays 0 from ACK1 through ACK2 and is re-evaluated in IDLE from the cycle after return.
- Non-specific EOI: clears the highest-priority set ISR bit, searched starting at `priority_rotate` and wrapping 7→0. No-op if `isr`==0.
- Specific EOI: clears `isr[eoi_level]`.
- Rotation: on an EOI with `eoi_rotate`=1, `priority_rotate` ← (cleared level + 1) mod 8. For a non-specific EOI with nothing cleared, there is no rotation.
- `set_priority`: `priority_rotate` ← (`eoi_level`+1) mod 8.
- Simultaneous events:
  - EOI and ISR set in the same cycle: the EOI clear is applied first, then the set. If both target the same bit, the set wins.
  - `set_priority` and an EOI rotate in the same cycle: the EOI rotate wins.
- EOI and `set_priority` are accepted in every state.
- Reset mid-handshake returns the block to IDLE with all reset values on the next edge. A subsequent `inta_n` rise is ignored.
- A `inta_fall` in ACK1 or ACK2 is impossible by construction. A `inta_rise` in IDLE or WAIT2 is ignored.

Decomposition:
- Shared package `pic_pkg`:
  - state enum {IDLE, ACK1, WAIT2, ACK2};
  - `NUM_IR`=8;
  - functions `onehot_to_level` and `rotated_highest(isr, rot)`.
- Sub-module `pic_eoi_unit` (combinational): ISR clear mask plus next `priority_rotate` from the EOI and `set_priority` inputs.
- The FSM, edge detect and registers stay in the top.

Test Plan:
- Handshake: `interrupt_vector`=8'h08, `icw2_base`=5'h10, two INTA pulses:
  - `int_out`=1 before the first pulse;
  - `isr`=8'h08 and `clear_irr`=8'h08 for one cycle after the first fall;
  - `data_out`=8'h83 with `data_out_en`=1 during the second low.
- AEOI: same sequence with `aeoi`=1 → `isr` returns to 0 in the cycle of the second `inta_rise`.
- Non-specific rotate EOI: `isr`=8'h24, `priority_rotate`=0, EOI with `eoi_rotate`=1 → `isr`=8'h20, `priority_rotate`=3.
- Spurious: `interrupt_vector` drops to 0 before the first `inta_fall`, `icw2_base`=5'h10 → `isr` unchanged, no `clear_irr`, `data_out`=8'h87.
- Collision: specific EOI level 2 in the same cycle the first `inta_fall` selects level 2 with `isr`=8'h04 → `isr`=8'h04 (set wins).
- Reset in WAIT2: assert `reset` for one cycle → IDLE, `isr`=0, `data_out_en` stays 0 through the following INTA pulse.
